// File: rtl/control_unit.sv
// Fetch/decode/execute sequencer for a one-bus accumulator datapath.
// Every strobe is a registered Moore output that tracks the state it belongs to.
module control_unit #(
    parameter int N   = 12,
    parameter int OPW = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] ir_in,
    input  logic         zero_flag,
    input  logic         mem_ready,
    output logic [5:0]   write_en,
    output logic [3:0]   read_en,
    output logic         inc_en,
    output logic         clr_en,
    output logic         alu_to_ac,
    output logic [1:0]   alu_op,
    output logic         pc_inc,
    output logic         mem_req,
    output logic         mem_we,
    output logic         busy,
    output logic         illegal
);

    typedef enum logic [4:0] {
        S_IDLE, S_F1, S_F2, S_F3, S_DEC,
        S_NOP, S_ILL, S_CLR, S_INC, S_MVR, S_ADD, S_SUB,
        S_O1, S_O2, S_O3,
        S_LD1, S_LD2, S_ST1, S_ST2, S_JP1, S_SKIP,
        S_HALT
    } state_t;

    // Which memory-operand instruction the shared operand-fetch states serve
    typedef enum logic [1:0] {OP_LD, OP_ST, OP_JP} mop_t;

    localparam logic [3:0] RD_DR   = 4'd1;
    localparam logic [3:0] RD_PC   = 4'd2;
    localparam logic [3:0] RD_AC   = 4'd5;
    localparam logic [3:0] RD_ACR  = 4'd13;
    localparam logic [5:0] WE_AR   = 6'b000001;
    localparam logic [5:0] WE_PC   = 6'b000010;
    localparam logic [5:0] WE_IR   = 6'b000100;
    localparam logic [5:0] WE_AC   = 6'b001000;
    localparam logic [5:0] WE_DR   = 6'b010000;

    state_t           r_state;
    state_t           w_next;
    mop_t             r_op;
    mop_t             w_dec_op;
    logic [OPW-1:0]   w_opcode;
    logic             w_unused_ir;

    logic [5:0] r_write_en, w_write_en;
    logic [3:0] r_read_en,  w_read_en;
    logic [1:0] r_alu_op,   w_alu_op;
    logic       r_inc_en, w_inc_en, r_clr_en, w_clr_en, r_alu_to_ac, w_alu_to_ac;
    logic       r_pc_inc, w_pc_inc, r_mem_req, w_mem_req, r_mem_we, w_mem_we;
    logic       r_busy, w_busy, r_illegal, w_illegal;

    assign w_opcode    = ir_in[N-1 -: OPW];
    assign w_unused_ir = &{1'b0, ir_in[N-OPW-1:0]};

    always_comb begin
        case (w_opcode)
            OPW'(6):  w_dec_op = OP_LD;
            OPW'(7):  w_dec_op = OP_ST;
            default:  w_dec_op = OP_JP;
        endcase
    end

    // State register; outputs are registered from the next state so they align with it
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_op        <= OP_JP;
            r_write_en  <= '0;
            r_read_en   <= '0;
            r_inc_en    <= 1'b0;
            r_clr_en    <= 1'b0;
            r_alu_to_ac <= 1'b0;
            r_alu_op    <= '0;
            r_pc_inc    <= 1'b0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_busy      <= 1'b0;
            r_illegal   <= 1'b0;
        end else begin
            r_state     <= w_next;
            if (r_state == S_DEC)
                r_op <= w_dec_op;
            r_write_en  <= w_write_en;
            r_read_en   <= w_read_en;
            r_inc_en    <= w_inc_en;
            r_clr_en    <= w_clr_en;
            r_alu_to_ac <= w_alu_to_ac;
            r_alu_op    <= w_alu_op;
            r_pc_inc    <= w_pc_inc;
            r_mem_req   <= w_mem_req;
            r_mem_we    <= w_mem_we;
            r_busy      <= w_busy;
            r_illegal   <= w_illegal;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (start) w_next = S_F1;
            S_F1:   w_next = S_F2;
            S_F2:   if (mem_ready) w_next = S_F3;
            S_F3:   w_next = S_DEC;
            S_DEC: begin
                case (w_opcode)
                    OPW'(0):  w_next = S_NOP;
                    OPW'(1):  w_next = S_CLR;
                    OPW'(2):  w_next = S_INC;
                    OPW'(3):  w_next = S_MVR;
                    OPW'(4):  w_next = S_ADD;
                    OPW'(5):  w_next = S_SUB;
                    OPW'(6), OPW'(7), OPW'(8): w_next = S_O1;
                    OPW'(9):  w_next = zero_flag ? S_O1 : S_SKIP;
                    OPW'(15): w_next = S_HALT;
                    default:  w_next = S_ILL;
                endcase
            end
            S_O1:   w_next = S_O2;
            S_O2:   if (mem_ready) w_next = S_O3;
            S_O3: begin
                case (r_op)
                    OP_LD:   w_next = S_LD1;
                    OP_ST:   w_next = S_ST1;
                    default: w_next = S_JP1;
                endcase
            end
            S_LD1:  if (mem_ready) w_next = S_LD2;
            S_ST1:  w_next = S_ST2;
            S_ST2:  if (mem_ready) w_next = S_F1;
            S_HALT: w_next = S_HALT;
            default: w_next = S_F1;
        endcase
    end

    always_comb begin
        w_write_en  = '0;
        w_read_en   = '0;
        w_inc_en    = 1'b0;
        w_clr_en    = 1'b0;
        w_alu_to_ac = 1'b0;
        w_alu_op    = 2'd0;
        w_pc_inc    = 1'b0;
        w_mem_req   = 1'b0;
        w_mem_we    = 1'b0;
        w_illegal   = 1'b0;
        w_busy      = (w_next != S_IDLE) && (w_next != S_HALT);
        case (w_next)
            S_F1, S_O1:        begin w_read_en = RD_PC; w_write_en = WE_AR; end
            S_F2, S_O2, S_LD1: w_mem_req = 1'b1;
            S_F3:              begin w_read_en = RD_DR; w_write_en = WE_IR; w_pc_inc = 1'b1; end
            // Operand address moves DR->AR; a jump leaves PC for the target load instead
            S_O3:              begin w_read_en = RD_DR; w_write_en = WE_AR; w_pc_inc = (r_op != OP_JP); end
            S_CLR:             w_clr_en = 1'b1;
            S_INC:             w_inc_en = 1'b1;
            S_MVR:             w_read_en = RD_ACR;
            S_ADD:             begin w_alu_op = 2'd1; w_alu_to_ac = 1'b1; end
            S_SUB:             begin w_alu_op = 2'd2; w_alu_to_ac = 1'b1; end
            S_LD2:             begin w_read_en = RD_DR; w_write_en = WE_AC; end
            S_ST1:             begin w_read_en = RD_AC; w_write_en = WE_DR; end
            S_ST2:             begin w_mem_req = 1'b1; w_mem_we = 1'b1; end
            S_JP1:             begin w_read_en = RD_DR; w_write_en = WE_PC; end
            S_SKIP:            w_pc_inc = 1'b1;
            S_ILL:             w_illegal = 1'b1;
            default: ;
        endcase
    end

    assign write_en  = r_write_en;
    assign read_en   = r_read_en;
    assign inc_en    = r_inc_en;
    assign clr_en    = r_clr_en;
    assign alu_to_ac = r_alu_to_ac;
    assign alu_op    = r_alu_op;
    assign pc_inc    = r_pc_inc;
    assign mem_req   = r_mem_req;
    assign mem_we    = r_mem_we;
    assign busy      = r_busy;
    assign illegal   = r_illegal;

endmodule

// File: tb/tb_control_unit.sv
// Random-program bench for control_unit: a per-instruction list of expected strobe
// vectors is built from the instruction semantics and compared every cycle.
module tb_control_unit;

    localparam int N = 12;

    logic         clk = 1'b0;
    logic         rst, start, zero_flag, mem_ready;
    logic [N-1:0] ir_in;
    logic [5:0]   write_en;
    logic [3:0]   read_en;
    logic         inc_en, clr_en, alu_to_ac;
    logic [1:0]   alu_op;
    logic         pc_inc, mem_req, mem_we, busy, illegal;

    always #5 clk = ~clk;

    control_unit #(.N(N), .OPW(4)) dut (
        .clk(clk), .rst(rst), .start(start), .ir_in(ir_in),
        .zero_flag(zero_flag), .mem_ready(mem_ready),
        .write_en(write_en), .read_en(read_en), .inc_en(inc_en),
        .clr_en(clr_en), .alu_to_ac(alu_to_ac), .alu_op(alu_op),
        .pc_inc(pc_inc), .mem_req(mem_req), .mem_we(mem_we),
        .busy(busy), .illegal(illegal)
    );

    logic [19:0] obs;
    assign obs = {write_en, read_en, inc_en, clr_en, alu_to_ac, alu_op,
                  pc_inc, mem_req, mem_we, busy, illegal};

    // gate: 0 = one cycle, 1 = until mem_ready, 2 = until start, 3 = forever
    typedef struct {
        logic [19:0] v;
        int          gate;
        string       name;
    } step_t;

    step_t q[$];
    int    n_cmp = 0;
    int    n_bad = 0;
    bit    prev_ready, prev_start, force_halt;

    function automatic logic [19:0] mk(input logic [5:0] we, input logic [3:0] rd,
                                       input logic inc, input logic clr, input logic a2ac,
                                       input logic [1:0] aop, input logic pci,
                                       input logic req, input logic mwe,
                                       input logic bsy, input logic ill);
        return {we, rd, inc, clr, a2ac, aop, pci, req, mwe, bsy, ill};
    endfunction

    task automatic push(input logic [19:0] v, input int gate, input string name);
        step_t s;
        s.v = v; s.gate = gate; s.name = name;
        q.push_back(s);
    endtask

    task automatic check(input string tag, input logic [19:0] got, input logic [19:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %05h expected %05h", tag, $time, got, exp);
        end
    endtask

    task automatic operand_fetch(input bit with_inc);
        push(mk(6'b000001, 4'd2, 0,0,0,2'd0, 0, 0,0,1,0), 0, "O1");
        push(mk(6'b000000, 4'd0, 0,0,0,2'd0, 0, 1,0,1,0), 1, "O2");
        push(mk(6'b000001, 4'd1, 0,0,0,2'd0, with_inc, 0,0,1,0), 0, "O3");
    endtask

    task automatic jump_exec();
        operand_fetch(1'b0);
        push(mk(6'b000010, 4'd1, 0,0,0,2'd0, 0, 0,0,1,0), 0, "JMP");
    endtask

    // Pick the next instruction, present it on ir_in, and queue its expected cycles
    task automatic refill();
        int op;
        op = force_halt ? 15 : $urandom_range(0, 14);
        zero_flag = 1'($urandom_range(0, 1));
        ir_in = {4'(op), 8'($urandom)};
        push(mk(6'b000001, 4'd2, 0,0,0,2'd0, 0, 0,0,1,0), 0, "F1");
        push(mk(6'b000000, 4'd0, 0,0,0,2'd0, 0, 1,0,1,0), 1, "F2");
        push(mk(6'b000100, 4'd1, 0,0,0,2'd0, 1, 0,0,1,0), 0, "F3");
        push(mk(6'b000000, 4'd0, 0,0,0,2'd0, 0, 0,0,1,0), 0, "DEC");
        case (op)
            0:  push(mk(0, 0,  0,0,0,2'd0, 0, 0,0,1,0), 0, "NOP");
            1:  push(mk(0, 0,  0,1,0,2'd0, 0, 0,0,1,0), 0, "CLAC");
            2:  push(mk(0, 0,  1,0,0,2'd0, 0, 0,0,1,0), 0, "INAC");
            3:  push(mk(0, 13, 0,0,0,2'd0, 0, 0,0,1,0), 0, "MVACR");
            4:  push(mk(0, 0,  0,0,1,2'd1, 0, 0,0,1,0), 0, "ADD");
            5:  push(mk(0, 0,  0,0,1,2'd2, 0, 0,0,1,0), 0, "SUB");
            6: begin
                operand_fetch(1'b1);
                push(mk(6'b000000, 4'd0, 0,0,0,2'd0, 0, 1,0,1,0), 1, "LDAC_rd");
                push(mk(6'b001000, 4'd1, 0,0,0,2'd0, 0, 0,0,1,0), 0, "LDAC_ld");
            end
            7: begin
                operand_fetch(1'b1);
                push(mk(6'b010000, 4'd5, 0,0,0,2'd0, 0, 0,0,1,0), 0, "STAC_dr");
                push(mk(6'b000000, 4'd0, 0,0,0,2'd0, 0, 1,1,1,0), 1, "STAC_wr");
            end
            8:  jump_exec();
            9: begin
                if (zero_flag) jump_exec();
                else push(mk(0, 0, 0,0,0,2'd0, 1, 0,0,1,0), 0, "JMPZ_skip");
            end
            15: push(20'd0, 3, "HALT");
            default: push(mk(0, 0, 0,0,0,2'd0, 0, 0,0,1,1), 0, "ILLEGAL");
        endcase
    endtask

    task automatic cyc();
        @(posedge clk); #1;
        if (q.size() > 0) begin
            case (q[0].gate)
                0: void'(q.pop_front());
                1: if (prev_ready) void'(q.pop_front());
                2: if (prev_start) void'(q.pop_front());
                default: ;
            endcase
        end
        if (q.size() == 0) refill();
        check(q[0].name, obs, q[0].v);
        mem_ready  = ($urandom_range(0, 2) == 0);
        start      = ($urandom_range(0, 3) == 0);
        prev_ready = mem_ready;
        prev_start = start;
    endtask

    task automatic do_reset(input string tag);
        rst   = 1'b1;
        start = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        check(tag, obs, 20'd0);
        q.delete();
        push(20'd0, 2, "IDLE");
        prev_start = 1'b0;
        prev_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; zero_flag = 1'b0; mem_ready = 1'b0;
        ir_in = '0; force_halt = 1'b0;
        @(posedge clk); #1;
        do_reset("reset");
        repeat (1500) cyc();

        // Reset while an instruction fetch has mem_req outstanding
        for (int i = 0; i < 200; i++) begin
            if (q[0].name == "F2") break;
            cyc();
        end
        check("reach_F2", {19'd0, q[0].name == "F2"}, 20'd1);
        mem_ready  = 1'b0;
        prev_ready = 1'b0;
        do_reset("reset_midF2");
        repeat (800) cyc();

        // Finish with HALT; random start pulses must not wake it
        force_halt = 1'b1;
        for (int i = 0; i < 300; i++) begin
            if (q[0].gate == 3) break;
            cyc();
        end
        check("halt_reached", 20'(q[0].gate), 20'd3);
        repeat (12) cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
